// File: rtl/vector_serializer_if.sv
// rtl/vector_serializer_if.sv - vector input handshake and element output stream bundle
interface vector_serializer_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic                  eof_in;
  logic [DATA_WIDTH-1:0] vector_in [N-1:0];
  logic                  ready_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_eof;

  modport slave (
    input  valid_in, eof_in, vector_in, out_ready,
    output ready_in, out_valid, out_data, out_last, out_eof
  );

  modport master (
    output valid_in, eof_in, vector_in, out_ready,
    input  ready_in, out_valid, out_data, out_last, out_eof
  );
endinterface

// File: rtl/vector_serializer.sv
// rtl/vector_serializer.sv - circular vector queue drained one element per beat
module vector_serializer #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  vector_serializer_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [15:0]                  drop_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH-1:0][N-1:0];
  logic [DEPTH-1:0]      mem_eof;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [IW-1:0]         elem_idx;
  logic                  full;
  logic                  push;
  logic                  drop;
  logic                  xfer;
  logic                  pop;
  logic                  at_last;

  // Handshake decode; ready_in deliberately ignores a same-cycle pop.
  always_comb begin
    full    = (count == CW'(DEPTH));
    at_last = (elem_idx == IW'(N - 1));
    push    = bus.valid_in & ~full;
    drop    = bus.valid_in & full;
    xfer    = bus.out_valid & bus.out_ready;
    pop     = xfer & at_last;
  end

  assign bus.ready_in  = ~full;
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem_data[rd_ptr][elem_idx];
  assign bus.out_last  = bus.out_valid & at_last;
  assign bus.out_eof   = bus.out_last & mem_eof[rd_ptr];
  assign occupancy     = count;

  // Vector storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      for (int i = 0; i < N; i++) begin
        mem_data[wr_ptr][i] <= bus.vector_in[i];
      end
      mem_eof[wr_ptr] <= bus.eof_in;
    end
  end

  // Pointers, element index, occupancy and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      elem_idx   <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (xfer) begin
        if (at_last) begin
          elem_idx <= '0;
          rd_ptr   <= rd_ptr + PW'(1);
        end else begin
          elem_idx <= elem_idx + IW'(1);
        end
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (drop && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_vector_serializer.sv
// tb/tb_vector_serializer.sv - directed self-checking bench for vector_serializer
module tb_vector_serializer;
  localparam int N  = 8;
  localparam int DW = 32;

  logic        clk;
  logic        rst;
  logic [2:0]  occupancy;
  logic [15:0] drop_count;
  int          n_checks;
  int          n_fail;

  vector_serializer_if #(.N(N), .DATA_WIDTH(DW)) bus ();

  vector_serializer #(.N(N), .DATA_WIDTH(DW), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .occupancy  (occupancy),
    .drop_count (drop_count)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_vec(input logic [31:0] base, input logic eof);
    bus.valid_in = 1'b1;
    bus.eof_in   = eof;
    for (int i = 0; i < N; i++) bus.vector_in[i] = base + 32'(i);
  endtask

  task automatic idle_in();
    bus.valid_in = 1'b0;
    bus.eof_in   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] d, input logic last, input logic eof);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"},  bus.out_data, d);
    check({tag, "_last"},  32'(bus.out_last), 32'(last));
    check({tag, "_eof"},   32'(bus.out_eof), 32'(eof));
  endtask

  initial begin
    int e;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.valid_in  = 1'b0;
    bus.eof_in    = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) bus.vector_in[i] = '0;
    step();
    do_reset();

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last",  32'(bus.out_last), 32'd0);
    check("rst_out_eof",   32'(bus.out_eof), 32'd0);
    check("rst_ready_in",  32'(bus.ready_in), 32'd1);
    check("rst_occ",       32'(occupancy), 32'd0);
    check("rst_drops",     32'(drop_count), 32'd0);

    // Single vector 0..7, out_ready held high
    bus.out_ready = 1'b1;
    drive_vec(32'd0, 1'b0);
    step();
    idle_in();
    for (int k = 0; k < N; k++) begin
      beat("t1", 32'(k), k == N - 1, 1'b0);
      step();
    end
    check("t1_occ_end",   32'(occupancy), 32'd0);
    check("t1_valid_end", 32'(bus.out_valid), 32'd0);

    // Backpressure with eof-tagged vector 10..17
    bus.out_ready = 1'b0;
    drive_vec(32'd10, 1'b1);
    step();
    idle_in();
    for (int k = 0; k < 5; k++) begin
      check("t2_stall_data", bus.out_data, 32'd10);
      step();
    end
    e = 0;
    for (int c = 0; c < 40 && e < N; c++) begin
      bus.out_ready = (c % 2 == 0);
      beat("t2", 32'd10 + 32'(e), e == N - 1, e == N - 1);
      if (bus.out_ready) e++;
      step();
    end
    bus.out_ready = 1'b0;
    check("t2_beats", 32'(e), 32'd8);
    check("t2_occ_end", 32'(occupancy), 32'd0);

    // Fill and drop: six pushes into a four-deep queue
    for (int v = 0; v < 6; v++) begin
      check("t3_ready_in", 32'(bus.ready_in), (v < 4) ? 32'd1 : 32'd0);
      drive_vec(32'h100 * 32'(v + 1), 1'b0);
      step();
    end
    idle_in();
    check("t3_occ",   32'(occupancy), 32'd4);
    check("t3_drops", 32'(drop_count), 32'd2);
    bus.out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < N; k++) begin
        beat("t3", 32'h100 * 32'(v + 1) + 32'(k), k == N - 1, 1'b0);
        step();
      end
    end
    check("t3_valid_end", 32'(bus.out_valid), 32'd0);

    // Wrap with simultaneous push/pop: one vector every N cycles
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c <= 81; c++) begin
      if (c % 8 == 0 && c < 80) drive_vec(32'h1000 + 32'h10 * 32'(c / 8), 1'b0);
      else idle_in();
      check("t4_valid", 32'(bus.out_valid), (c >= 1 && c <= 80) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 80)
        check("t4_data", bus.out_data, 32'h1000 + 32'h10 * 32'((c - 1) / 8) + 32'((c - 1) % 8));
      check("t4_occ_le1", 32'(occupancy <= 3'd1), 32'd1);
      step();
    end
    idle_in();
    check("t4_drops", 32'(drop_count), 32'd0);

    // Full queue with a pop on the same cycle as an incoming vector
    do_reset();
    for (int v = 0; v < 4; v++) begin
      drive_vec(32'h2000 + 32'h10 * 32'(v), 1'b0);
      step();
    end
    idle_in();
    check("t5_occ_full", 32'(occupancy), 32'd4);
    bus.out_ready = 1'b1;
    for (int k = 0; k < N - 1; k++) step();
    drive_vec(32'h2F00, 1'b0);
    check("t5_ready_full", 32'(bus.ready_in), 32'd0);
    check("t5_last", 32'(bus.out_last), 32'd1);
    check("t5_data", bus.out_data, 32'h2007);
    step();
    idle_in();
    bus.out_ready = 1'b0;
    check("t5_drops", 32'(drop_count), 32'd1);
    check("t5_ready_after", 32'(bus.ready_in), 32'd1);
    check("t5_occ_after", 32'(occupancy), 32'd3);
    check("t5_next_head", bus.out_data, 32'h2010);

    // Reset mid-drain of a four-vector backlog
    drive_vec(32'h2040, 1'b0);
    step();
    idle_in();
    check("t6_occ_backlog", 32'(occupancy), 32'd4);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("t6_mid_data", bus.out_data, 32'h2013);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive_vec(32'h2E00, 1'b1);
    step();
    rst = 1'b0;
    idle_in();
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_occ", 32'(occupancy), 32'd0);
    check("t6_drops", 32'(drop_count), 32'd0);
    check("t6_ready", 32'(bus.ready_in), 32'd1);
    bus.out_ready = 1'b1;
    drive_vec(32'h3000, 1'b1);
    step();
    idle_in();
    for (int k = 0; k < N; k++) begin
      beat("t6", 32'h3000 + 32'(k), k == N - 1, k == N - 1);
      step();
    end
    check("t6_occ_end", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
